matmul_sequencer: RTL and testbench

Upstream/downstream control stage for the 2x2 matrix_multiply core in the user project.
- Accepts a byte stream of 8 operands over a valid/ready interface and writes them into the core via its input_val/sel_in port.
- Pulses execute, waits a fixed compute latency, then reads the 4 results via sel_out.
- Emits each 17-bit result on a valid/ready output. Replaces manual io_in sequencing.

---
 rtl/matmul_pkg.sv | 27 ++
 rtl/matmul_delay_timer.sv | 41 ++++
 rtl/matmul_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared widths, counts and FSM encoding for the 2x2 matrix_multiply core
// and the sequencer that feeds and drains it.
package matmul_pkg;

    localparam int OPERAND_W  = 8;
    localparam int RESULT_W   = 17;
    localparam int N_OPERANDS = 8;
    localparam int N_RESULTS  = 4;
    localparam int TIMER_W    = 16;
    localparam int SEL_IN_W   = $clog2(N_OPERANDS);
    localparam int SEL_OUT_W  = $clog2(N_RESULTS);

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        SETTLE = 3'd1,
        EXEC   = 3'd2,
        WAIT   = 3'd3,
        READ   = 3'd4,
        OUT    = 3'd5
    } state_e;

    // The timer reports zero on the last cycle of a delay, so it is loaded with N-1.
    function automatic logic [TIMER_W-1:0] delay_load(input int unsigned cycles);
        return (cycles == 0) ? '0 : TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/matmul_delay_timer.sv
// Loadable down-counter with a zero flag; times both the compute wait and
// the sel_out-to-result read delay.
module matmul_delay_timer
    import matmul_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    // next count: clear, load, or decrement towards zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/matmul_sequencer.sv
// Streams 8 operand bytes into the matrix_multiply core, fires execute, waits
// out the compute latency and drains the 4 results over a valid/ready port.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned COMPUTE_LAT = 2,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPERAND_W-1:0] in_data,
    output logic [OPERAND_W-1:0] mm_input_val,
    output logic [SEL_IN_W-1:0]  mm_sel_in,
    output logic                 mm_execute,
    output logic [SEL_OUT_W-1:0] mm_sel_out,
    input  logic [RESULT_W-1:0]  mm_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RESULT_W-1:0]  out_data,
    output logic [SEL_OUT_W-1:0] out_index,
    output logic                 busy,
    output logic                 done
);

    localparam logic [TIMER_W-1:0]   WAIT_LOAD    = delay_load(COMPUTE_LAT);
    localparam logic [TIMER_W-1:0]   READ_LOAD    = delay_load(READ_LAT);
    localparam logic [SEL_IN_W-1:0]  LAST_OPERAND = SEL_IN_W'(N_OPERANDS - 1);
    localparam logic [SEL_OUT_W-1:0] LAST_RESULT  = SEL_OUT_W'(N_RESULTS - 1);

    state_e               state_q, state_d;
    logic [SEL_IN_W-1:0]  count_q, count_d;
    logic [SEL_OUT_W-1:0] k_q, k_d;
    logic [OPERAND_W-1:0] input_val_q, input_val_d;
    logic [SEL_IN_W-1:0]  sel_in_q, sel_in_d;
    logic                 execute_q, execute_d;
    logic [SEL_OUT_W-1:0] sel_out_q, sel_out_d;
    logic                 out_valid_q, out_valid_d;
    logic [RESULT_W-1:0]  out_data_q, out_data_d;
    logic [SEL_OUT_W-1:0] out_index_q, out_index_d;
    logic                 done_q, done_d;
    logic                 accept_s, handshake_s, timer_zero_s, timer_load_s;
    logic [TIMER_W-1:0]   timer_val_s;

    // The done cycle is held off so a new set can never start alongside done.
    assign in_ready    = (state_q == LOAD) && !clear && !done_q;
    assign accept_s    = in_valid && in_ready;
    assign handshake_s = out_valid_q && out_ready;
    assign busy        = !((state_q == LOAD) && (count_q == '0));

    assign timer_load_s = ((state_d == WAIT) && (state_q != WAIT)) ||
                          ((state_d == READ) && (state_q != READ));
    assign timer_val_s  = (state_d == WAIT) ? WAIT_LOAD : READ_LOAD;

    matmul_delay_timer u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (clear),
        .load_i     (timer_load_s),
        .load_val_i (timer_val_s),
        .zero_o     (timer_zero_s)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept_s && (count_q == LAST_OPERAND)) begin
                        state_d = SETTLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
                SETTLE: state_d = EXEC;
                EXEC:   state_d = (COMPUTE_LAT == 0) ? READ : WAIT;
                WAIT: begin
                    if (timer_zero_s) begin
                        state_d = READ;
                    end else begin
                        state_d = WAIT;
                    end
                end
                READ: begin
                    if (timer_zero_s) begin
                        state_d = OUT;
                    end else begin
                        state_d = READ;
                    end
                end
                OUT: begin
                    if (handshake_s) begin
                        state_d = (k_q == LAST_RESULT) ? LOAD : READ;
                    end else begin
                        state_d = OUT;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // output and datapath next values; core-facing selects hold across clear
    always_comb begin
        count_d     = count_q;
        k_d         = k_q;
        input_val_d = input_val_q;
        sel_in_d    = sel_in_q;
        sel_out_d   = sel_out_q;
        execute_d   = (state_d == EXEC);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        done_d      = 1'b0;
        if (clear) begin
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept_s) begin
                        input_val_d = in_data;
                        sel_in_d    = count_q;
                        count_d     = count_q + SEL_IN_W'(1);
                    end else begin
                        count_d = count_q;
                    end
                end
                EXEC, WAIT: begin
                    if (state_d == READ) begin
                        k_d       = '0;
                        sel_out_d = '0;
                    end else begin
                        k_d = k_q;
                    end
                end
                READ: begin
                    if (timer_zero_s) begin
                        out_data_d  = mm_result;
                        out_index_d = k_q;
                        out_valid_d = 1'b1;
                    end else begin
                        out_valid_d = out_valid_q;
                    end
                end
                OUT: begin
                    if (handshake_s) begin
                        out_valid_d = 1'b0;
                        if (k_q == LAST_RESULT) begin
                            done_d  = 1'b1;
                            count_d = '0;
                        end else begin
                            k_d       = k_q + SEL_OUT_W'(1);
                            sel_out_d = k_q + SEL_OUT_W'(1);
                        end
                    end else begin
                        out_valid_d = out_valid_q;
                    end
                end
                default: count_d = count_q;
            endcase
        end
    end

    // datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            k_q         <= '0;
            input_val_q <= '0;
            sel_in_q    <= '0;
            execute_q   <= 1'b0;
            sel_out_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            k_q         <= k_d;
            input_val_q <= input_val_d;
            sel_in_q    <= sel_in_d;
            execute_q   <= execute_d;
            sel_out_q   <= sel_out_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            done_q      <= done_d;
        end
    end

    assign mm_input_val = input_val_q;
    assign mm_sel_in    = sel_in_q;
    assign mm_execute   = execute_q;
    assign mm_sel_out   = sel_out_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_index    = out_index_q;
    assign done         = done_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a behavioural 2x2 core attached.
module tb_matmul_sequencer;

    logic        clk, reset, clear, in_valid, in_ready;
    logic [7:0]  in_data, mm_input_val;
    logic [2:0]  mm_sel_in;
    logic        mm_execute;
    logic [1:0]  mm_sel_out, out_index;
    logic [16:0] mm_result, out_data;
    logic        out_valid, out_ready, busy, done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    matmul_sequencer #(.COMPUTE_LAT(2), .READ_LAT(1)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mm_input_val(mm_input_val), .mm_sel_in(mm_sel_in),
        .mm_execute(mm_execute), .mm_sel_out(mm_sel_out), .mm_result(mm_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Stand-in core: latches input_val at sel_in every cycle, multiplies on execute.
    logic [7:0]  core_op [8];
    logic [16:0] core_c  [4];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) core_op[i] <= 8'd0;
            for (int i = 0; i < 4; i++) core_c[i]  <= 17'd0;
        end else begin
            core_op[mm_sel_in] <= mm_input_val;
            if (mm_execute) begin
                core_c[0] <= 17'(core_op[0]) * 17'(core_op[4]) + 17'(core_op[1]) * 17'(core_op[6]);
                core_c[1] <= 17'(core_op[0]) * 17'(core_op[5]) + 17'(core_op[1]) * 17'(core_op[7]);
                core_c[2] <= 17'(core_op[2]) * 17'(core_op[4]) + 17'(core_op[3]) * 17'(core_op[6]);
                core_c[3] <= 17'(core_op[2]) * 17'(core_op[5]) + 17'(core_op[3]) * 17'(core_op[7]);
            end
        end
    end
    assign mm_result = core_c[mm_sel_out];

    // Event log sampled on the falling edge.
    int          acc_cyc[$], exec_cyc[$], ov_cyc[$];
    logic [7:0]  val_log[$];
    logic [2:0]  sel_log[$];
    logic [16:0] res_data[$];
    logic [1:0]  res_idx[$];
    int          done_cnt = 0;
    logic        ready_at_done = 1'b0;
    logic        prev_acc = 1'b0, prev_ov = 1'b0;

    always @(negedge clk) begin
        if (prev_acc) begin
            sel_log.push_back(mm_sel_in);
            val_log.push_back(mm_input_val);
        end
        prev_acc = in_valid && in_ready;
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        if (mm_execute) exec_cyc.push_back(cyc);
        if (out_valid && !prev_ov) ov_cyc.push_back(cyc);
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
            res_data.push_back(out_data);
            res_idx.push_back(out_index);
        end
        if (done) begin
            done_cnt++;
            ready_at_done = in_ready;
        end
    end

    task automatic clear_logs();
        acc_cyc.delete(); exec_cyc.delete(); ov_cyc.delete();
        val_log.delete(); sel_log.delete();
        res_data.delete(); res_idx.delete();
        done_cnt = 0;
    endtask

    task automatic send_bytes(input logic [7:0] b [8], input bit gapped, input int nb);
        int n;
        bit tog;
        n = 0;
        tog = 1'b1;
        for (int g = 0; g < 200 && n < nb; g++) begin
            @(posedge clk); #1;
            in_valid = gapped ? tog : 1'b1;
            in_data  = b[n];
            tog      = ~tog;
            @(negedge clk);
            if (in_valid && in_ready) n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int g = 0; g < 300 && done_cnt == 0; g++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if ({out_valid, out_data, out_index, mm_input_val, mm_sel_in, mm_execute, mm_sel_out, done} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got ov=%0d data=%0d idx=%0d val=%0d sel_in=%0d exe=%0d sel_out=%0d done=%0d, required all 0",
                     out_valid, out_data, out_index, mm_input_val, mm_sel_in, mm_execute, mm_sel_out, done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got in_ready=%0d busy=%0d, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0]  ops [8];
        logic [16:0] exp_c [4];
        int d_exec, d_ov;
        ops   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        exp_c = '{17'd19, 17'd22, 17'd43, 17'd50};
        clear_logs();
        send_bytes(ops, 1'b0, 8);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            logic [16:0] gd;
            logic [1:0]  gi;
            gd = (i < res_data.size()) ? res_data[i] : 17'h1ffff;
            gi = (i < res_idx.size()) ? res_idx[i] : 2'd3;
            n_vec++;
            if (i >= res_data.size() || gd !== exp_c[i] || gi !== 2'(i)) begin
                n_err++;
                $display("FAIL basic_result[%0d]: got %0d idx %0d, required %0d idx %0d", i, gd, gi, exp_c[i], i);
            end
        end
        n_vec++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL basic_done: got %0d pulses, required 1", done_cnt);
        end
        d_exec = (exec_cyc.size() > 0 && acc_cyc.size() == 8) ? exec_cyc[0] - acc_cyc[7] : -1;
        n_vec++;
        if (exec_cyc.size() != 1 || d_exec != 2) begin
            n_err++;
            $display("FAIL basic_execute: got %0d high cycles at +%0d, required 1 at +2", exec_cyc.size(), d_exec);
        end
        d_ov = (exec_cyc.size() > 0 && ov_cyc.size() > 0) ? ov_cyc[0] - exec_cyc[0] : -1;
        n_vec++;
        if (d_ov != 4) begin
            n_err++;
            $display("FAIL basic_out_latency: got %0d, required 4", d_ov);
        end
        n_vec++;
        if (ready_at_done !== 1'b0) begin
            n_err++;
            $display("FAIL done_in_ready: got %0d, required 0", ready_at_done);
        end
    endtask

    task automatic test_max();
        logic [7:0] ops [8];
        ops = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        clear_logs();
        send_bytes(ops, 1'b0, 8);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            logic [16:0] gd;
            gd = (i < res_data.size()) ? res_data[i] : 17'h0;
            n_vec++;
            if (gd !== 17'd130050) begin
                n_err++;
                $display("FAIL max_result[%0d]: got %0d, required 130050", i, gd);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  ops [8];
        logic [16:0] exp_c [4];
        ops   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        exp_c = '{17'd19, 17'd22, 17'd43, 17'd50};
        clear_logs();
        send_bytes(ops, 1'b0, 8);
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (out_valid && out_index == 2'd1) break;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            n_vec++;
            if ({out_valid, out_index, out_data, mm_sel_out} !== {1'b1, 2'd2, 17'd43, 2'd2}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got ov=%0d idx=%0d data=%0d sel_out=%0d, required 1 2 43 2",
                         c, out_valid, out_index, out_data, mm_sel_out);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done();
        for (int i = 0; i < 4; i++) begin
            logic [16:0] gd;
            gd = (i < res_data.size()) ? res_data[i] : 17'h1ffff;
            n_vec++;
            if (gd !== exp_c[i]) begin
                n_err++;
                $display("FAIL stall_result[%0d]: got %0d, required %0d", i, gd, exp_c[i]);
            end
        end
        n_vec++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL stall_done: got %0d pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_gapped();
        logic [7:0]  ops [8];
        logic [16:0] exp_c [4];
        ops   = '{8'd2, 8'd0, 8'd1, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        exp_c = '{17'd8, 17'd10, 17'd22, 17'd26};
        clear_logs();
        send_bytes(ops, 1'b1, 8);
        wait_done();
        n_vec++;
        if (acc_cyc.size() != 8) begin
            n_err++;
            $display("FAIL gapped_accepts: got %0d, required 8", acc_cyc.size());
        end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] gs;
            logic [7:0] gv;
            gs = (i < sel_log.size()) ? sel_log[i] : 3'd0;
            gv = (i < val_log.size()) ? val_log[i] : 8'd0;
            n_vec++;
            if (i >= sel_log.size() || gs !== 3'(i) || gv !== ops[i]) begin
                n_err++;
                $display("FAIL gapped_write[%0d]: got sel_in=%0d val=%0d, required %0d %0d", i, gs, gv, i, ops[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            logic [16:0] gd;
            gd = (i < res_data.size()) ? res_data[i] : 17'h1ffff;
            n_vec++;
            if (gd !== exp_c[i]) begin
                n_err++;
                $display("FAIL gapped_result[%0d]: got %0d, required %0d", i, gd, exp_c[i]);
            end
        end
    endtask

    task automatic test_clear();
        logic [7:0]  part [8];
        logic [7:0]  ops [8];
        logic [16:0] exp_c [4];
        part  = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        ops   = '{8'd3, 8'd1, 8'd0, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4};
        exp_c = '{17'd6, 17'd10, 17'd6, 17'd8};
        clear_logs();
        send_bytes(part, 1'b0, 4);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'd77;
        clear    = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_in_ready: got %0d, required 0", in_ready);
        end
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || acc_cyc.size() != 4 || mm_sel_in !== 3'd3 || mm_input_val !== 8'd9) begin
            n_err++;
            $display("FAIL clear_state: got busy=%0d accepts=%0d sel_in=%0d val=%0d, required 0 4 3 9",
                     busy, acc_cyc.size(), mm_sel_in, mm_input_val);
        end
        clear_logs();
        send_bytes(ops, 1'b0, 8);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            logic [16:0] gd;
            gd = (i < res_data.size()) ? res_data[i] : 17'h1ffff;
            n_vec++;
            if (gd !== exp_c[i]) begin
                n_err++;
                $display("FAIL clear_result[%0d]: got %0d, required %0d", i, gd, exp_c[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]  ops [8];
        logic [7:0]  ops2 [8];
        logic [16:0] exp_c [4];
        bit seen;
        ops   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        ops2  = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd0, 8'd0, 8'd1};
        exp_c = '{17'd5, 17'd6, 17'd7, 17'd8};
        clear_logs();
        send_bytes(ops, 1'b0, 8);
        seen = 1'b0;
        for (int g = 0; g < 100 && !seen; g++) begin
            @(negedge clk);
            seen = out_valid;
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (!seen || {out_valid, out_data, out_index, mm_input_val, mm_sel_in, mm_execute, mm_sel_out, done} !== 35'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got seen=%0d ov=%0d data=%0d idx=%0d val=%0d sel_in=%0d sel_out=%0d, required 1 and all 0",
                     seen, out_valid, out_data, out_index, mm_input_val, mm_sel_in, mm_sel_out);
        end
        clear_logs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_release: got in_ready=%0d busy=%0d, required 1 0", in_ready, busy);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (done_cnt != 0) begin
            n_err++;
            $display("FAIL midreset_no_done: got %0d pulses, required 0", done_cnt);
        end
        send_bytes(ops2, 1'b0, 8);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            logic [16:0] gd;
            gd = (i < res_data.size()) ? res_data[i] : 17'h1ffff;
            n_vec++;
            if (gd !== exp_c[i]) begin
                n_err++;
                $display("FAIL midreset_result[%0d]: got %0d, required %0d", i, gd, exp_c[i]);
            end
        end
        n_vec++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL midreset_done: got %0d pulses, required 1", done_cnt);
        end
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_gapped();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
